// File: rtl/seg7_value_formatter.sv
// Binary-to-7-segment digit formatter: serial double-dabble conversion followed by
// sign, decimal point, leading-zero blanking and overflow marking.
module seg7_value_formatter #(
   parameter int         DIGITS     = 6,
   parameter int         VALUE_W    = 32,
   parameter logic [3:0] BLANK_CODE = 4'd10,
   parameter logic [3:0] DASH_CODE  = 4'd11
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         start,
   input  logic [VALUE_W-1:0]           value,
   input  logic                         is_signed,
   input  logic                         blank_lead,
   input  logic [$clog2(DIGITS+1)-1:0]  dp_pos,
   output logic                         busy,
   output logic                         done,
   output logic                         ovf,
   output logic [4*DIGITS-1:0]          digits,
   output logic [DIGITS-1:0]            dp
);

   localparam int BCD_W = 4 * DIGITS;
   localparam int DP_W  = $clog2(DIGITS + 1);
   localparam int CNT_W = $clog2(VALUE_W + 1);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SHIFT  = 2'd1;
   localparam logic [1:0] ST_FORMAT = 2'd2;

   logic [1:0]         state;
   logic [CNT_W-1:0]   cnt;
   logic               sticky;
   logic               neg_r;
   logic               blank_r;
   logic [DP_W-1:0]    dp_pos_r;
   logic [VALUE_W-1:0] mag;
   logic [BCD_W-1:0]   bcd;
   logic [BCD_W-1:0]   bcd_adj;
   logic [BCD_W-1:0]   fmt_digits;
   logic [DIGITS-1:0]  fmt_dp;
   logic               fmt_ovf;

   function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] b);
      logic [BCD_W-1:0] r;
      r = b;
      for (int k = 0; k < DIGITS; k++) begin
         if (b[4*k +: 4] >= 4'd5) r[4*k +: 4] = b[4*k +: 4] + 4'd3;
      end
      return r;
   endfunction

   assign bcd_adj = add3(bcd);
   assign busy    = (state != ST_IDLE);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state  <= ST_IDLE;
         cnt    <= '0;
         sticky <= 1'b0;
         done   <= 1'b0;
         ovf    <= 1'b0;
         digits <= {DIGITS{BLANK_CODE}};
         dp     <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state  <= ST_SHIFT;
                  cnt    <= '0;
                  sticky <= 1'b0;
               end
            end
            ST_SHIFT: begin
               // A 1 leaving the top nibble means the value needs more digits than we have.
               sticky <= sticky | bcd_adj[BCD_W-1];
               cnt    <= cnt + 1'b1;
               if (cnt == CNT_W'(VALUE_W - 1)) state <= ST_FORMAT;
            end
            ST_FORMAT: begin
               digits <= fmt_digits;
               dp     <= fmt_dp;
               ovf    <= fmt_ovf;
               done   <= 1'b1;
               state  <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Datapath registers carry no reset; they are always reloaded on an accepted start.
   always_ff @(posedge clk) begin
      if (state == ST_IDLE && start) begin
         neg_r    <= is_signed & value[VALUE_W-1];
         mag      <= (is_signed & value[VALUE_W-1]) ? (~value + 1'b1) : value;
         blank_r  <= blank_lead;
         dp_pos_r <= dp_pos;
         bcd      <= '0;
      end else if (state == ST_SHIFT) begin
         bcd <= {bcd_adj[BCD_W-2:0], mag[VALUE_W-1]};
         mag <= {mag[VALUE_W-2:0], 1'b0};
      end
   end

   int   avail;
   int   p;
   int   hi;
   logic zero_run;

   always_comb begin
      fmt_ovf    = sticky | (neg_r & (bcd[BCD_W-1 -: 4] != 4'd0));
      avail      = neg_r ? DIGITS - 1 : DIGITS;
      p          = 0;
      hi         = 0;
      zero_run   = 1'b1;
      fmt_digits = {DIGITS{BLANK_CODE}};
      fmt_dp     = '0;
      if (int'(dp_pos_r) >= 1 && int'(dp_pos_r) <= DIGITS - 1) p = int'(dp_pos_r);

      // Scan from the left so zero_run tracks "this digit and all above are zero".
      for (int k = DIGITS - 1; k >= 0; k--) begin
         if (k < avail) begin
            zero_run = zero_run & (bcd[4*k +: 4] == 4'd0);
            if (!(blank_r && zero_run && k > p && k != 0)) begin
               fmt_digits[4*k +: 4] = bcd[4*k +: 4];
               if (k > hi) hi = k;
            end
         end
      end

      for (int k = 0; k < DIGITS; k++) begin
         if (neg_r && k == hi + 1) fmt_digits[4*k +: 4] = DASH_CODE;
         fmt_dp[k] = (p != 0) && (k == p);
      end

      if (fmt_ovf) begin
         fmt_digits = {DIGITS{DASH_CODE}};
         fmt_dp     = '0;
      end
   end

endmodule

// File: tb/tb_seg7_value_formatter.sv
// Directed scoreboard bench for seg7_value_formatter (DIGITS=6, VALUE_W=32).
// Digit words are written as hex: A = blank, B = dash.
module tb_seg7_value_formatter;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic [31:0] value = '0;
   logic        is_signed = 1'b0;
   logic        blank_lead = 1'b0;
   logic [2:0]  dp_pos = '0;
   logic        busy, done, ovf;
   logic [23:0] digits;
   logic [5:0]  dp;

   seg7_value_formatter #(
      .DIGITS(6), .VALUE_W(32), .BLANK_CODE(4'd10), .DASH_CODE(4'd11)
   ) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .value(value),
      .is_signed(is_signed), .blank_lead(blank_lead), .dp_pos(dp_pos),
      .busy(busy), .done(done), .ovf(ovf), .digits(digits), .dp(dp)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      logic [23:0] dg;
      logic [5:0]  dpv;
      logic        ov;
      int          sc;
   } exp_t;

   exp_t        sb[$];
   int          n_chk = 0;
   int          n_fail = 0;
   int          cyc = 0;
   int          n_done = 0;
   logic [23:0] last_dg = 24'hAAAAAA;
   logic [5:0]  last_dp = '0;
   logic        last_ov = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Output monitor: pops the scoreboard on every done pulse.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (done) begin
         n_done++;
         if (sb.size() == 0) begin
            chk("spurious_done", {31'd0, done}, 32'd0);
         end else begin
            e = sb.pop_front();
            chk({e.tag, "_digits"}, {8'd0, digits}, {8'd0, e.dg});
            chk({e.tag, "_dp"}, {26'd0, dp}, {26'd0, e.dpv});
            chk({e.tag, "_ovf"}, {31'd0, ovf}, {31'd0, e.ov});
            chk({e.tag, "_latency"}, cyc - e.sc, 32'd33);
            last_dg = e.dg;
            last_dp = e.dpv;
            last_ov = e.ov;
         end
      end
   end

   task automatic issue(input string tag, input logic [31:0] v, input logic sg, input logic bl,
                        input logic [2:0] dpp, input logic [23:0] edg, input logic [5:0] edp,
                        input logic eov);
      exp_t e;
      @(negedge clk);
      value = v; is_signed = sg; blank_lead = bl; dp_pos = dpp; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
      chk({tag, "_done_low"}, {31'd0, done}, 32'd0);
      chk({tag, "_held_digits"}, {8'd0, digits}, {8'd0, last_dg});
      chk({tag, "_held_ovf"}, {31'd0, ovf}, {31'd0, last_ov});
      e.tag = tag; e.dg = edg; e.dpv = edp; e.ov = eov; e.sc = cyc;
      sb.push_back(e);
   endtask

   task automatic wait_done(input string tag, output int busy_cycles);
      int target;
      target = n_done + 1;
      busy_cycles = 1;
      for (int i = 0; i < 40 && n_done < target; i++) begin
         @(posedge clk);
         #2;
         if (busy) busy_cycles++;
      end
      chk({tag, "_done_seen"}, n_done, target);
   endtask

   initial begin
      int bc;
      int n0;

      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_ovf", {31'd0, ovf}, 32'd0);
      chk("rst_digits", {8'd0, digits}, 32'h00AAAAAA);
      chk("rst_dp", {26'd0, dp}, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;

      issue("zero", 32'd0, 1'b0, 1'b1, 3'd0, 24'hAAAAA0, 6'b000000, 1'b0);
      wait_done("zero", bc);
      chk("zero_busy_cycles", bc, 32'd33);

      // Each following issue starts in the done cycle of the previous one (back-to-back).
      issue("v1234", 32'd1234, 1'b0, 1'b1, 3'd2, 24'hAA1234, 6'b000100, 1'b0);
      wait_done("v1234", bc);
      issue("v5", 32'd5, 1'b0, 1'b1, 3'd2, 24'hAAA005, 6'b000100, 1'b0);
      wait_done("v5", bc);
      issue("m42_bl", 32'hFFFFFFD6, 1'b1, 1'b1, 3'd0, 24'hAAAB42, 6'b000000, 1'b0);
      wait_done("m42_bl", bc);
      issue("m42_nb", 32'hFFFFFFD6, 1'b1, 1'b0, 3'd0, 24'hB00042, 6'b000000, 1'b0);
      wait_done("m42_nb", bc);
      issue("v999999", 32'd999999, 1'b0, 1'b1, 3'd0, 24'h999999, 6'b000000, 1'b0);
      wait_done("v999999", bc);
      issue("v1000000", 32'd1000000, 1'b0, 1'b1, 3'd2, 24'hBBBBBB, 6'b000000, 1'b1);
      wait_done("v1000000", bc);
      issue("m99999", 32'hFFFE7961, 1'b1, 1'b1, 3'd0, 24'hB99999, 6'b000000, 1'b0);
      wait_done("m99999", bc);
      issue("m100000", 32'hFFFE7960, 1'b1, 1'b1, 3'd0, 24'hBBBBBB, 6'b000000, 1'b1);
      wait_done("m100000", bc);
      issue("min_neg", 32'h80000000, 1'b1, 1'b1, 3'd0, 24'hBBBBBB, 6'b000000, 1'b1);
      wait_done("min_neg", bc);

      // Abort a conversion with reset at E10.
      issue("abort", 32'd555, 1'b0, 1'b1, 3'd0, 24'hAAA555, 6'b000000, 1'b0);
      repeat (10) @(posedge clk);
      #1;
      reset_n = 1'b0;
      #1;
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_done", {31'd0, done}, 32'd0);
      chk("abort_ovf", {31'd0, ovf}, 32'd0);
      chk("abort_digits", {8'd0, digits}, 32'h00AAAAAA);
      chk("abort_dp", {26'd0, dp}, 32'd0);
      sb.delete();
      last_dg = 24'hAAAAAA; last_dp = '0; last_ov = 1'b0;
      n0 = n_done;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (40) @(posedge clk);
      #2;
      chk("abort_no_done", n_done, n0);
      chk("abort_idle", {31'd0, busy}, 32'd0);

      issue("v1_dp5", 32'd1, 1'b0, 1'b1, 3'd5, 24'h000001, 6'b100000, 1'b0);
      wait_done("v1_dp5", bc);
      issue("v7_dp6", 32'd7, 1'b0, 1'b1, 3'd6, 24'hAAAAA7, 6'b000000, 1'b0);
      wait_done("v7_dp6", bc);

      // A second start at E5 must be ignored.
      issue("ign", 32'd77, 1'b0, 1'b1, 3'd0, 24'hAAAA77, 6'b000000, 1'b0);
      repeat (5) @(negedge clk);
      value = 32'd123456; blank_lead = 1'b0; dp_pos = 3'd3; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("ign_busy", {31'd0, busy}, 32'd1);
      wait_done("ign", bc);
      repeat (40) @(posedge clk);
      #2;
      chk("ign_single_done", {31'd0, busy}, 32'd0);
      chk("sb_drained", sb.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/seg7_value_formatter.md
# seg7_value_formatter

Sequential, parametrised binary-to-display formatter for the 7-segment parameter readout. It accepts one binary value per request, converts it to BCD by iterative double-dabble (one bit per clock), and applies sign, decimal-point placement, leading-zero blanking and overflow marking. It produces packed per-digit codes for the existing hex-digit decoders, so effect-specific display logic only supplies a scaled value and a format.

## Interface
Parameters:
- DIGITS, 6, number of display digits; index 0 is the rightmost digit.
- VALUE_W, 32, width of the binary input.
- BLANK_CODE, 10, 4-bit digit code that the decoder renders as blank.
- DASH_CODE, 11, 4-bit digit code that the decoder renders as "-".

Ports:
- clk  in  1  system clock; single clock domain.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  conversion request; sampled only in IDLE.
- value  in  VALUE_W  binary value, captured on the accepting edge.
- is_signed  in  1  treat `value` as two's complement; captured with `value`.
- blank_lead  in  1  enable leading-zero blanking; captured with `value`.
- dp_pos  in  $clog2(DIGITS+1)  number of fractional digits (0 = no point); captured with `value`.
- busy  out  1  conversion in progress.
- done  out  1  one-cycle pulse when new digits are valid.
- ovf  out  1  last result did not fit; held until the next done.
- digits  out  4*DIGITS  digit codes; digit k occupies bits [4k+3:4k]; held between conversions.
- dp  out  DIGITS  decimal-point enables; bit k lights the point on digit k.

## Operation
- States: IDLE, SHIFT, FORMAT.
- IDLE:
  - `start` = 1 captures `value`, `is_signed`, `blank_lead` and `dp_pos`.
  - Captures `neg` = `is_signed` & `value`[VALUE_W-1].
  - Captures `mag` = the two's-complement negation when `neg`, else `value`; unsigned VALUE_W bits, so the most negative input yields 2^(VALUE_W-1).
  - Clears the BCD register (4*DIGITS bits), the overflow flag and the bit counter, then goes to SHIFT.
- SHIFT runs exactly VALUE_W cycles. Each cycle:
  - Adds 3 to every BCD nibble that is ≥ 5.
  - Shifts {bcd, mag} left by one.
  - Sets a sticky overflow flag if a 1 leaves the BCD MSB.
- After the last shift, the state goes to FORMAT.
- FORMAT (1 cycle) writes the outputs and returns to IDLE. Available magnitude digits: A = DIGITS-1 if `neg`, else DIGITS.
  - Overflow = sticky flag, or (`neg` and BCD nibble DIGITS-1 ≠ 0).
  - On overflow: all digits = DASH_CODE, `dp` = 0, `ovf` = 1.
  - Otherwise `ovf` = 0. Effective point position p = `dp_pos` if 1 ≤ `dp_pos` ≤ DIGITS-1, else 0. `dp` is one-hot at bit p when p ≠ 0.
  - Blanking: when `blank_lead` = 1, digit k < A is replaced by BLANK_CODE if it and all higher digits are 0 and k > p. Digit 0 is never blanked.
  - Sign: when `neg`, DASH_CODE goes in the digit immediately left of the highest non-blank digit. With `blank_lead` = 0 that is digit DIGITS-1.
  - Unused digits (index ≥ A, not holding the dash) are BLANK_CODE.
- `busy` = (state ≠ IDLE). `start` while busy is ignored, not queued.
- Reset (asynchronous, any state, including mid-conversion):
  - State goes to IDLE; `busy` = 0, `done` = 0, `ovf` = 0.
  - All digits = BLANK_CODE, `dp` = 0.
  - No `done` is generated for an aborted conversion.

## Timing
- Let edge E0 be the edge that samples `start` = 1 in IDLE. `busy` rises after E0.
- Shifts occur on edges E1..E(VALUE_W).
- FORMAT updates `digits`, `dp` and `ovf` and sets `done` = 1 on edge E(VALUE_W+1).
- In that same cycle `busy` = 0 and a new `start` is accepted.
- Latency from the start edge to `done` high is VALUE_W+1 edges; `done` stays high for exactly one cycle.
- Outputs are registered and change only at the FORMAT edge or on reset. Inputs other than `start` may change freely after E0.

## Test plan
All scenarios use DIGITS = 6, VALUE_W = 32. Digits are listed 5..0, B = blank, D = dash.
- value 0, unsigned, `blank_lead` = 1, `dp_pos` 0 -> B,B,B,B,B,0; `dp` = 0; `done` exactly 33 edges after the start edge; `busy` high for 33 cycles.
- value 1234, `dp_pos` 2, blanked -> B,B,1,2,3,4 with `dp` = 6'b000100. Value 5, `dp_pos` 2 -> B,B,B,0,0,5 ("0.05").
- Signed -42, blanked -> B,B,B,D,4,2. Signed -42, `blank_lead` = 0 -> D,0,0,0,4,2.
- Unsigned 999999 -> 9,9,9,9,9,9 with `ovf` = 0.
- Unsigned 1000000 -> all D with `ovf` = 1.
- Signed -99999 -> D,9,9,9,9,9.
- Signed -100000 -> all D with `ovf` = 1.
- Signed 32'h80000000 -> all D with `ovf` = 1.
- Second `start` with a different value at E5 -> ignored; result matches the first value.
- `reset_n` low at E10 -> `busy` = 0, all digits B, no `done` pulse.
- Back-to-back `start` in the `done` cycle -> accepted; next `done` 33 edges later.
